// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: one request per cycle, byte-strobed writes, in-order responses LATENCY cycles after accept.
// No response backpressure; addr_ok drops when DEPTH requests are outstanding unless one retires this cycle.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [WORDS];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept;
    logic                  resp;
    logic [LATENCY-1:0]    vld_q;
    logic [LATENCY-1:0]    wr_q;
    logic [31:0]           dat_q [LATENCY];
    logic [3:0]            inflight_q;
    logic [3:0]            inflight_d;
    logic                  unused_addr_bits;

    assign idx              = addr_i[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

    // Outputs are gated by reset so a response due during the reset cycle never surfaces.
    assign resp      = ~reset & vld_q[LATENCY-1];
    assign addr_ok_o = ~reset & ((inflight_q < 4'(DEPTH)) | resp);
    assign accept    = req_i & addr_ok_o;
    assign data_ok_o = resp;
    assign rdata_o   = (resp & ~wr_q[LATENCY-1]) ? dat_q[LATENCY-1] : 32'h0;

    always_ff @(posedge clk) begin
        if (accept & wr_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Read word is sampled before this edge's write lands; same-index write+read cannot coexist.
    always_ff @(posedge clk) begin
        wr_q[0]  <= wr_i;
        dat_q[0] <= (accept & ~wr_i) ? mem_q[idx] : 32'h0;
        for (int i = 1; i < LATENCY; i++) begin
            wr_q[i]  <= wr_q[i-1];
            dat_q[i] <= dat_q[i-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({accept, resp})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 4'd0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

endmodule
